// File: rtl/lfsr_stream.sv
// Fibonacci LFSR pseudo-random word source with a valid/ready output stream.
// Optional build macro LFSR_STREAM_LOCKUP_RECOVER_EN: reload SEED on all-zero state.
module lfsr_stream #(
  parameter int          WIDTH = 32,
  parameter logic [31:0] TAPS  = 32'h088C_8892,
  parameter logic [31:0] SEED  = 32'h00BD_F3A0,
  parameter int          STEPS = 1,
  parameter int          OUT_W = 32,
  parameter int          CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [OUT_W-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             lockup_o
);

  typedef enum logic {IDLE, RUN} fsm_e;

  // Resize a 32-bit parameter to WIDTH bits; bits at or above WIDTH are dropped.
  function automatic logic [WIDTH-1:0] fit_width(input logic [31:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < WIDTH) r[i % WIDTH] = v[i];
    end
    return r;
  endfunction

  localparam logic [WIDTH-1:0] TAP_MASK = fit_width(TAPS);
  localparam logic [WIDTH-1:0] SEED_V   = fit_width(SEED);

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAP_MASK)};
  endfunction

  function automatic logic [WIDTH-1:0] lfsr_advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    r = s;
    for (int i = 0; i < STEPS; i++) r = lfsr_step(r);
    return r;
  endfunction

  logic [WIDTH-1:0] state_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             vld_p0;
  logic             lock_p0;
  fsm_e             fsm_p0;
  logic             state_zero;
  logic             handshake;

  assign state_zero = (state_p0 == '0);

`ifdef LFSR_STREAM_LOCKUP_RECOVER_EN
  assign valid_o = vld_p0 & ~state_zero;
`else
  assign valid_o = vld_p0;
`endif

  assign handshake = valid_o & ready_i;
  assign data_o    = state_p0[OUT_W-1:0];
  assign count_o   = cnt_p0;
  assign lockup_o  = lock_p0;

  // Stage p0: LFSR state, stream control and status registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_p0 <= SEED_V;
      fsm_p0   <= IDLE;
      vld_p0   <= 1'b0;
      cnt_p0   <= '0;
      lock_p0  <= 1'b0;
    end else begin
      if (state_zero) lock_p0 <= 1'b1;
      if (seed_load_i) begin
        state_p0 <= seed_i;
        cnt_p0   <= '0;
        fsm_p0   <= IDLE;
        vld_p0   <= 1'b0;
      end else begin
        case (fsm_p0)
          IDLE: begin
            if (enable_i) begin
              fsm_p0 <= RUN;
              vld_p0 <= 1'b1;
            end
          end
          RUN: begin
            if (handshake) begin
              state_p0 <= lfsr_advance(state_p0);
              cnt_p0   <= cnt_p0 + CNT_W'(1);
              if (!enable_i) begin
                fsm_p0 <= IDLE;
                vld_p0 <= 1'b0;
              end
            end
          end
          default: begin
            fsm_p0 <= IDLE;
            vld_p0 <= 1'b0;
          end
        endcase
`ifdef LFSR_STREAM_LOCKUP_RECOVER_EN
        if (state_zero) state_p0 <= SEED_V;
`endif
      end
    end
  end

endmodule

// File: tb/tb_lfsr_stream.sv
// Bench for lfsr_stream: default instance plus a STEPS=4 / CNT_W=4 / OUT_W=16 instance
// on shared stimulus, both checked every cycle against a word-level reference model.
module tb_lfsr_stream;

  localparam logic [31:0] TAPS = 32'h088C_8892;
  localparam logic [31:0] SEED = 32'h00BD_F3A0;
`ifdef LFSR_STREAM_LOCKUP_RECOVER_EN
  localparam bit RECOV = 1'b1;
`else
  localparam bit RECOV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, sl, rdy;
  logic [31:0] seed;

  logic        v0, l0, v1, l1;
  logic [31:0] d0;
  logic [15:0] c0;
  logic [15:0] d1;
  logic [3:0]  c1;

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  always #5 clk = ~clk;

  lfsr_stream dut (
    .clk_i(clk), .reset_i(rst), .enable_i(en), .seed_load_i(sl), .seed_i(seed),
    .valid_o(v0), .ready_i(rdy), .data_o(d0), .count_o(c0), .lockup_o(l0)
  );

  lfsr_stream #(.STEPS(4), .CNT_W(4), .OUT_W(16)) dut2 (
    .clk_i(clk), .reset_i(rst), .enable_i(en), .seed_load_i(sl), .seed_i(seed),
    .valid_o(v1), .ready_i(rdy), .data_o(d1), .count_o(c1), .lockup_o(l1)
  );

  // n single LFSR shifts: shift left, feed back parity of the tapped bits.
  function automatic logic [31:0] adv(input logic [31:0] s, input int n);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < n; i++)
      r = (r << 1) | ((($countones(r & TAPS) % 2) == 1) ? 32'd1 : 32'd0);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: current word, running flag, delivered count, sticky lockup.
  logic [31:0] ms   [2];
  bit          mrun [2];
  int unsigned mcnt [2];
  bit          mlock[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit zero, shown, hs;
      zero  = (ms[k] == 32'd0);
      shown = mrun[k] && !(RECOV && zero);
      hs    = shown && rdy;
      if (rst) begin
        ms[k] = SEED; mrun[k] = 1'b0; mcnt[k] = 0; mlock[k] = 1'b0;
      end else begin
        if (zero) mlock[k] = 1'b1;
        if (sl) begin
          ms[k] = seed; mcnt[k] = 0; mrun[k] = 1'b0;
        end else begin
          if (!mrun[k]) mrun[k] = en;
          else if (hs) begin
            ms[k]   = adv(ms[k], (k == 0) ? 1 : 4);
            mcnt[k] = (mcnt[k] + 1) % ((k == 0) ? 65536 : 16);
            mrun[k] = en;
          end
          if (RECOV && zero) ms[k] = SEED;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("valid0", v0, mrun[0] && !(RECOV && ms[0] == 0));
      check("data0",  d0, ms[0]);
      check("count0", c0, mcnt[0]);
      check("lock0",  l0, mlock[0]);
      check("valid1", v1, mrun[1] && !(RECOV && ms[1] == 0));
      check("data1",  d1, ms[1][15:0]);
      check("count1", c1, mcnt[1]);
      check("lock1",  l1, mlock[1]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sl = 1'b0; rdy = 1'b0; seed = 32'd0;
    cyc(2);
    armed = 1'b1;
    check("rst_valid", v0, 1'b0);
    check("rst_data",  d0, 32'h00BD_F3A0);
    check("rst_count", c0, 0);
    check("rst_lock",  l0, 1'b0);

    // Back-to-back stream from reset
    rst = 1'b0; en = 1'b1; rdy = 1'b1;
    cyc(1);
    check("first_valid", v0, 1'b1);
    check("first_data",  d0, 32'h00BD_F3A0);
    check("first_count", c0, 0);
    cyc(1);
    check("second_data",  d0, 32'h017B_E741);
    check("second_count", c0, 1);
    check("steps4_data",  d1, 16'h3A09);
    check("steps4_count", c1, 1);
    cyc(3);
    check("fourth_data", d0, 32'h0BDF_3A09);
    check("fourth_count", c0, 4);
    cyc(13);
    check("wrap_count", c1, 1);
    check("count17", c0, 17);

    // Stall with ready low
    rdy = 1'b0;
    cyc(5);
    check("stall_valid", v0, 1'b1);
    check("stall_data",  d0, adv(SEED, 17));
    check("stall_count", c0, 17);
    rdy = 1'b1;
    cyc(1);
    check("resume_data",  d0, adv(SEED, 18));
    check("resume_count", c0, 18);

    // Disable while a word is pending
    en = 1'b0; rdy = 1'b0;
    cyc(3);
    check("dis_hold_valid", v0, 1'b1);
    rdy = 1'b1;
    cyc(1);
    check("dis_idle_valid", v0, 1'b0);
    check("dis_count", c0, 19);
    rdy = 1'b0;
    cyc(1);
    check("idle_valid", v0, 1'b0);

    // Seed load flushes a pending word
    en = 1'b1;
    cyc(1);
    check("reen_valid", v0, 1'b1);
    sl = 1'b1; seed = 32'h1;
    cyc(1);
    sl = 1'b0; en = 1'b0;
    check("seed_valid", v0, 1'b0);
    check("seed_data",  d0, 32'h1);
    check("seed_count", c0, 0);

    // All-zero seed
    sl = 1'b1; seed = 32'h0;
    cyc(1);
    sl = 1'b0;
    check("zero_data", d0, 32'h0);
    check("zero_lock_pre", l0, 1'b0);
    cyc(1);
    check("zero_lock", l0, 1'b1);
    check("zero_after", d0, RECOV ? SEED : 32'h0);
    cyc(1);
    check("zero_sticky", l0, 1'b1);

    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst_clear_lock", l0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      en   = ($urandom_range(0, 3) != 0);
      rdy  = ($urandom_range(0, 2) != 0);
      sl   = ($urandom_range(0, 49) == 0);
      seed = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      cyc(1);
    end
    rst = 1'b0; sl = 1'b0;
    cyc(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
